// File: rtl/rom_burst_reader.sv
// rom_burst_reader -- burst read engine in front of a synchronous single-port
// ROM. One read per cycle under credit flow control. Returned words go into a
// first-word-fall-through FIFO that drives a valid/ready stream.
// Optional feature macro: ROMIF_ADDR_WRAP_EN. When defined, the address counter
// wraps at 2^AW and o_err is tied low. When undefined, a burst that would run
// past the top address is truncated there, and o_err pulses with o_done.
//
// state | meaning
// IDLE  | waiting for i_start; the first read issues on the accepting edge
// READ  | issuing reads while words remain and credit is available
// DRAIN | all reads issued; waiting for ROM returns and an empty FIFO
// FIN   | one-cycle completion state
module rom_burst_reader #(
  parameter int DW      = 16,
  parameter int AW      = 7,
  parameter int CW      = 8,
  parameter int ROM_LAT = 1,
  parameter int DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [AW-1:0] i_addr,
  input  logic [CW-1:0] i_wordcnt,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic          o_cen,
  output logic [AW-1:0] o_a,
  input  logic [DW-1:0] i_q
);

  localparam int PW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_rem;
  logic          r_zero;
  logic          r_cen;
  logic [AW-1:0] r_a;
  logic [ROM_LAT-1:0] r_vpipe;
  logic [NW-1:0] r_infl;
  logic [NW-1:0] r_fcnt;
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [DW-1:0] r_mem [DEPTH];
  logic          r_done;

  logic [CW-1:0] w_eff_cnt;
  logic          w_issue;
  logic [AW-1:0] w_issue_addr;
  logic          w_tap;
  logic          w_pop;
  logic          w_credit;
  logic          w_drained;
  logic          w_fin_pulse;
  logic [NW:0]   w_outstanding;
  logic [NW-1:0] w_fcnt_nxt;

`ifdef ROMIF_ADDR_WRAP_EN
  assign w_eff_cnt = i_wordcnt;
  assign o_err     = 1'b0;
`else
  // Wide enough to hold both i_addr + i_wordcnt and 2^AW without overflow.
  localparam int EW = ((CW > AW) ? CW : AW) + 1;

  logic [EW-1:0] w_span;
  logic [EW-1:0] w_end;
  logic          w_trunc;
  logic          r_trunc;
  logic          r_err;

  assign w_span    = (EW'(1) << AW) - EW'(i_addr);
  assign w_end     = EW'(i_addr) + EW'(i_wordcnt);
  assign w_trunc   = w_end > (EW'(1) << AW);
  // When truncating, span < i_wordcnt, so it always fits in CW bits.
  assign w_eff_cnt = w_trunc ? CW'(w_span) : i_wordcnt;
  assign o_err     = r_err;

  // Remember whether the accepted burst was cut short, and flag it with o_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trunc <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && i_start) r_trunc <= w_trunc;
      r_err <= w_fin_pulse && r_trunc;
    end
  end
`endif

  assign w_tap         = r_vpipe[ROM_LAT-1];
  assign o_valid       = (r_fcnt != '0);
  assign w_pop         = o_valid && i_ready;
  // A pop in this cycle is not counted as credit until the next cycle.
  assign w_outstanding = {1'b0, r_fcnt} + {1'b0, r_infl};
  assign w_credit      = w_outstanding < (NW+1)'(DEPTH);
  assign w_fcnt_nxt    = r_fcnt + NW'(w_tap) - NW'(w_pop);
  // DRAIN never issues, so after this edge only the tap can retire a read.
  assign w_drained     = (w_fcnt_nxt == '0) && (r_infl == NW'(w_tap));

  // Normal bursts: o_done follows the edge that pops the last word.
  // Zero-count bursts: nothing is popped, so o_done follows the FIN cycle.
  assign w_fin_pulse = ((r_state == S_DRAIN) && (w_state_nxt == S_FIN)) ||
                       ((r_state == S_FIN) && r_zero);

  assign o_busy = (r_state != S_IDLE);
  assign o_done = r_done;
  assign o_cen  = r_cen;
  assign o_a    = r_a;
  assign o_data = o_valid ? r_mem[r_rd] : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and read issue decision.
  // The FIFO and the return pipe are always empty in IDLE, so the first read
  // needs no credit check.
  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_issue_addr = r_addr;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_eff_cnt == '0) begin
            w_state_nxt = S_FIN;
          end else begin
            w_state_nxt  = S_READ;
            w_issue      = 1'b1;
            w_issue_addr = i_addr;
          end
        end
      end
      S_READ: begin
        if (r_rem == '0)   w_state_nxt = S_DRAIN;
        else if (w_credit) w_issue     = 1'b1;
      end
      S_DRAIN: if (w_drained) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the burst on start, then step the address and the remaining count per issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_rem  <= '0;
      r_zero <= 1'b0;
    end else if (r_state == S_IDLE && i_start) begin
      r_addr <= i_addr + AW'(1);
      r_rem  <= (w_eff_cnt == '0) ? '0 : w_eff_cnt - CW'(1);
      r_zero <= (w_eff_cnt == '0);
    end else if (w_issue) begin
      r_addr <= r_addr + AW'(1);
      r_rem  <= r_rem - CW'(1);
    end
  end

  // Registered ROM port: chip enable low only in cycles with an issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cen <= 1'b1;
      r_a   <= '0;
    end else begin
      r_cen <= ~w_issue;
      if (w_issue) r_a <= w_issue_addr;
    end
  end

  // Track in-flight reads: a latency-deep valid pipe and a count of outstanding reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vpipe <= '0;
      r_infl  <= '0;
    end else begin
      r_vpipe[0] <= ~r_cen;
      for (int i = 1; i < ROM_LAT; i++) r_vpipe[i] <= r_vpipe[i-1];
      r_infl <= r_infl + NW'(w_issue) - NW'(w_tap);
    end
  end

  // FIFO pointers and occupancy. Credit control keeps pushes from ever hitting a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_tap) r_wr <= r_wr + PW'(1);
      if (w_pop) r_rd <= r_rd + PW'(1);
      r_fcnt <= w_fcnt_nxt;
    end
  end

  // FIFO storage. o_data is gated by o_valid, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (w_tap) r_mem[r_wr] <= i_q;
  end

  // Completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= w_fin_pulse;
  end

endmodule
